seq_enable_pipe_bank: RTL and testbench
=======================================

// Module: seq_enable_pipe_bank
// PURPOSE
//  Parametrised multi-lane, multi-stage enabled register pipeline.
//  - Each input lane is captured only when its own enable bit is set; otherwise it holds.
//  - Captured words then shift through DEPTH-1 further stages under a global stall.
//  - Adds sync clear, valid tracking, per-lane dirty flags and a capture counter.
//  - Data-path staging block between bus-level producers and consumers in the netlist benchmarks.
// PARAMETERS
//  WIDTH    8   bits per lane
//  LANES    4   number of independent lanes (>=1)
//  DEPTH    2   pipeline stages (>=1); latency d->q = DEPTH cycles
//  RST_VAL  0   WIDTH-bit value loaded into every data register on rst/clr
//  CNT_W    16  width of capture counter
// PORTS
//  clk        in   1            clock, all state updates on posedge
//  rst        in   1            reset: synchronous, active-high
//  clr        in   1            sync clear of data/valid/dirty; counter kept
//  stall      in   1            freeze every stage (no capture, no shift)
//  in_valid   in   1            input word presented this cycle
//  en         in   LANES        per-lane capture enable at stage 0
//  d          in   LANES*WIDTH  input lanes, lane l = d[l*WIDTH +: WIDTH]
//  q          out  LANES*WIDTH  last-stage data, same lane packing
//  out_valid  out  1            last-stage valid
//  dirty      out  LANES        lane l captured at least once since rst/clr
//  cap_cnt    out  CNT_W        number of accepted stage-0 captures
// BEHAVIOUR
//  Priority each cycle: rst > clr > stall > normal.
//  rst: all data regs = RST_VAL, all valid bits = 0, dirty = 0, cap_cnt = 0.
//  clr: same as rst except cap_cnt holds its value.
//  stall=1 (no rst/clr): every register holds, including cap_cnt and dirty.
//  Normal, stage 0 lane l:
//   - loads d lane l iff in_valid && en[l];
//   - otherwise holds its previous value (partial update merges with the old word).
//  Normal, stage 0 valid <= in_valid && |en.
//   - in_valid with en==0: no capture, valid bubble, no count.
//   - en!=0 with in_valid==0: ignored.
//  Stages k=1..DEPTH-1: data and valid copy from stage k-1 every non-stall cycle.
//   - Bubbles advance; registers are never held individually.
//  q / out_valid = stage DEPTH-1 registers.
//   - DEPTH=1: q equals stage 0 and latency is 1 cycle.
//  dirty[l] sets on any stage-0 capture of lane l; cleared only by rst/clr.
//  cap_cnt increments by 1 per cycle with stage-0 valid capture.
//   - Wraps modulo 2^CNT_W; 2^CNT_W-1 -> 0 with no sticky flag.
//  rst/clr mid-stream: in-flight words are discarded.
//   - First output after release appears DEPTH cycles after the first accepted capture.
//  clr and stall together: clr wins.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Package seq_enable_pkg holds:
//   - lane_t typedef (logic [WIDTH-1:0] via parameterised struct or localparam width);
//   - helper function lane_sel(bus,l) for lane extraction.
//  Sub-module seq_enable_lane_reg: one WIDTH register with rst/clr/stall/en priority.
//   - Instantiated LANES x DEPTH via generate.
//   - Stages k>0 tie en=1.
//  Top holds the valid shift chain, dirty flags and cap_cnt.
// TESTING
//  1 Reset: rst=1 for 2 cycles, RST_VAL=8'hA5.
//    -> q=32'hA5A5A5A5, out_valid=0, dirty=0, cap_cnt=0.
//  2 Full load: in_valid=1, en=4'hF, d=32'h11223344, DEPTH=2.
//    -> q=32'h11223344, out_valid=1 exactly 2 cycles later; cap_cnt=1.
//  3 Partial: after test 2, d=32'hAABBCCDD, en=4'b0101.
//    -> q=32'h11BB33DD two cycles later; dirty=4'hF.
//  4 Stall: stall=1 for 3 cycles with in_valid=1, en=4'hF.
//    -> q, out_valid and cap_cnt frozen; resume shifts with no word lost or duplicated.
//  5 Clear vs stall: clr=1 with stall=1 and a word in flight.
//    -> next cycle q=RST_VAL, out_valid=0, dirty=0; cap_cnt unchanged.
//  6 Wrap: CNT_W=4, 17 consecutive captures -> cap_cnt=1.
//    Also: in_valid=1 with en=0 -> bubble, out_valid=0 and no count.

Source files
------------

// File: rtl/seq_enable_pipe_bank_pkg.sv
// Shared lane type and lane-extraction helper for the enabled pipeline bank.
package seq_enable_pkg;

    localparam int LANE_W    = 8;
    localparam int MAX_LANES = 16;

    typedef logic [LANE_W-1:0] lane_t;

    function automatic lane_t lane_sel(input logic [MAX_LANES*LANE_W-1:0] bus, input int unsigned l);
        return bus[l*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/seq_enable_pipe_bank_if.sv
// Control, data and status bundle of the enabled pipeline bank (clk/rst stay outside).
interface seq_enable_pipe_bank_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                    clr;
    logic                    stall;
    logic                    in_valid;
    logic [LANES-1:0]        en;
    logic [LANES*WIDTH-1:0]  d;
    logic [LANES*WIDTH-1:0]  q;
    logic                    out_valid;
    logic [LANES-1:0]        dirty;
    logic [CNT_W-1:0]        cap_cnt;

    modport master (
        output clr, stall, in_valid, en, d,
        input  q, out_valid, dirty, cap_cnt
    );

    modport slave (
        input  clr, stall, in_valid, en, d,
        output q, out_valid, dirty, cap_cnt
    );
endinterface

// File: rtl/seq_enable_pipe_bank_lane_reg.sv
// One lane register: rst > clr > stall > en; 1-cycle latency, stall holds the value.
module seq_enable_lane_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             stall,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= RST_VAL;
        end else if (!stall && en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_enable_pipe_bank.sv
// Multi-lane enabled capture followed by a DEPTH-stage shift; latency d->q = DEPTH cycles.
// stall freezes every stage and the counter; clr wipes data/valid/dirty but keeps the count.
module seq_enable_pipe_bank
    import seq_enable_pkg::*;
#(
    parameter int               WIDTH   = LANE_W,
    parameter int               LANES   = 4,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_enable_pipe_bank_if.slave bus
);

    logic [DEPTH-1:0][LANES*WIDTH-1:0] stg;
    logic [DEPTH-1:0]                  vld;
    logic [LANES-1:0]                  lane_cap;
    logic                              cap;
    logic [LANES-1:0]                  dirty_r;
    logic [CNT_W-1:0]                  cnt_r;

    assign lane_cap = bus.en & {LANES{bus.in_valid}};
    assign cap      = |lane_cap;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [WIDTH-1:0] lane_d;
            logic [WIDTH-1:0] lane_q;
            logic             lane_en;

            // Stage 0 merges enabled lanes into the held word; later stages always shift.
            if (k == 0) begin : g_in
                assign lane_d  = bus.d[l*WIDTH +: WIDTH];
                assign lane_en = lane_cap[l];
            end else begin : g_sh
                assign lane_d  = stg[k-1][l*WIDTH +: WIDTH];
                assign lane_en = 1'b1;
            end

            seq_enable_lane_reg #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_reg (
                .clk   (clk),
                .rst   (rst),
                .clr   (bus.clr),
                .stall (bus.stall),
                .en    (lane_en),
                .d     (lane_d),
                .q     (lane_q)
            );

            assign stg[k][l*WIDTH +: WIDTH] = lane_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            vld <= '0;
        end else if (!bus.stall) begin
            vld[0] <= cap;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            dirty_r <= '0;
        end else if (!bus.stall) begin
            dirty_r <= dirty_r | lane_cap;
        end
    end

    // Counter survives clr so software can track lifetime captures across flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!bus.clr && !bus.stall && cap) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bus.q         = stg[DEPTH-1];
    assign bus.out_valid = vld[DEPTH-1];
    assign bus.dirty     = dirty_r;
    assign bus.cap_cnt   = cnt_r;

endmodule

// File: tb/tb_seq_enable_pipe_bank.sv
// Directed bench: expected output words queued at issue, popped by a monitor on each new valid output.
module tb_seq_enable_pipe_bank;

    localparam int               WIDTH   = 8;
    localparam int               LANES   = 4;
    localparam int               DEPTH   = 2;
    localparam int               CNT_W   = 4;
    localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;

    logic clk;
    logic rst;

    seq_enable_pipe_bank_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) bus ();

    seq_enable_pipe_bank #(
        .WIDTH   (WIDTH),
        .LANES   (LANES),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] e, input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.en       = e;
        bus.d        = data;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.en       = 4'h0;
        bus.d        = 32'h0;
    endtask

    // Monitor: a word is new only if the pipe advanced on the preceding edge.
    initial begin
        logic adv;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            adv = !bus.stall;
            @(negedge clk);
            if (bus.out_valid === 1'b1 && adv) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h, expected no word", bus.q);
                end else begin
                    e = exp_q.pop_front();
                    chk("q_word", bus.q, e);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        bus.clr   = 1'b0;
        bus.stall = 1'b0;
        idle();
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_q", bus.q, 32'hA5A5A5A5);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_dirty", 32'(bus.dirty), 32'h0);
        chk("rst_cap_cnt", 32'(bus.cap_cnt), 32'h0);

        // Full load, DEPTH-cycle latency
        issue(4'hF, 32'h11223344);
        exp_q.push_back(32'h11223344);
        cyc();
        idle();
        chk("full_lat1_valid", 32'(bus.out_valid), 32'h0);
        cyc();
        chk("full_lat2_valid", 32'(bus.out_valid), 32'h1);
        chk("full_cap_cnt", 32'(bus.cap_cnt), 32'h1);

        // Partial update merges into the held word
        issue(4'b0101, 32'hAABBCCDD);
        exp_q.push_back(32'h11BB33DD);
        cyc();
        idle();
        cyc();
        chk("partial_valid", 32'(bus.out_valid), 32'h1);
        chk("partial_dirty", 32'(bus.dirty), 32'hF);
        chk("partial_cap_cnt", 32'(bus.cap_cnt), 32'h2);

        // Stall with a word in stage 0
        issue(4'hF, 32'h55667788);
        exp_q.push_back(32'h55667788);
        cyc();
        bus.stall = 1'b1;
        issue(4'hF, 32'h99AABBCC);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_q", bus.q, 32'h11BB33DD);
            chk("stall_out_valid", 32'(bus.out_valid), 32'h0);
            chk("stall_cap_cnt", 32'(bus.cap_cnt), 32'h3);
        end
        bus.stall = 1'b0;
        idle();
        cyc();
        chk("resume_valid", 32'(bus.out_valid), 32'h1);
        cyc();
        chk("resume_no_dup", 32'(bus.out_valid), 32'h0);
        chk("resume_cap_cnt", 32'(bus.cap_cnt), 32'h3);

        // Clear beats stall and discards the in-flight word
        issue(4'hF, 32'hCAFEBABE);
        cyc();
        idle();
        bus.clr   = 1'b1;
        bus.stall = 1'b1;
        cyc();
        bus.clr   = 1'b0;
        bus.stall = 1'b0;
        chk("clr_q", bus.q, 32'hA5A5A5A5);
        chk("clr_out_valid", 32'(bus.out_valid), 32'h0);
        chk("clr_dirty", 32'(bus.dirty), 32'h0);
        chk("clr_cap_cnt", 32'(bus.cap_cnt), 32'h4);
        cyc();
        chk("clr_discard_valid", 32'(bus.out_valid), 32'h0);

        // First output after clear arrives DEPTH cycles after capture
        issue(4'hF, 32'h01020304);
        exp_q.push_back(32'h01020304);
        cyc();
        idle();
        chk("post_clr_lat1", 32'(bus.out_valid), 32'h0);
        cyc();
        chk("post_clr_lat2", 32'(bus.out_valid), 32'h1);

        // in_valid with no enables is a bubble and does not count
        issue(4'h0, 32'hFFFFFFFF);
        cyc();
        idle();
        cyc();
        chk("bubble_valid", 32'(bus.out_valid), 32'h0);
        chk("bubble_q", bus.q, 32'h01020304);
        chk("bubble_cap_cnt", 32'(bus.cap_cnt), 32'h5);

        // Counter wrap: 17 captures from reset in a 4-bit counter
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_cap_cnt", 32'(bus.cap_cnt), 32'h0);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i + 8'h30);
            issue(4'hF, {4{b}});
            exp_q.push_back({4{b}});
            cyc();
        end
        idle();
        cyc();
        cyc();
        cyc();
        chk("wrap_cap_cnt", 32'(bus.cap_cnt), 32'h1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
